sort_array_mem: RTL and testbench
=================================

Name: sort_array_mem

Overview:
- Array-storage slave directly downstream of the insertion-sort datapath; serves its AR/R read and AW/W write traffic plus a B write-response channel.
- Holds 2**ADDR_WDTH words of DATA_WDTH bits.
- Performs address range checking against arr_size.
- Has a host side-port so the bench or top level can preload the unsorted array and read back the sorted result.

Parameters:
- ADDR_WDTH, 4: address width; memory depth = 2**ADDR_WDTH.
- DATA_WDTH, 32: word width.
- RESP_WDTH, 1: response width; 0 = OKAY, 1 = SLVERR.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arr_size  in  ADDR_WDTH  number of valid elements; address >= arr_size is out of range.
- ar_valid  in  1  read address valid.
- ar_ready  out  1  read address accepted.
- ar_address  in  ADDR_WDTH  read address.
- r_valid  out  1  read data valid.
- r_ready  in  1  read data consumed.
- r_data  out  DATA_WDTH  read data.
- r_resp  out  RESP_WDTH  read response.
- aw_valid  in  1  write address valid.
- aw_ready  out  1  write address accepted.
- aw_address  in  ADDR_WDTH  write address.
- w_valid  in  1  write data valid.
- w_ready  out  1  write data accepted.
- w_data  in  DATA_WDTH  write data.
- b_valid  out  1  write response valid.
- b_ready  in  1  write response consumed.
- b_resp  out  RESP_WDTH  write response.
- host_we  in  1  host write strobe.
- host_addr  in  ADDR_WDTH  host address (read and write).
- host_wdata  in  DATA_WDTH  host write data.
- host_rdata  out  DATA_WDTH  combinational read of mem[host_addr]; no range check.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All memory words cleared to 0.
  - Read FSM to RD_IDLE; write FSM to WR_IDLE; AW/W holding registers cleared.
  - Output values: ar_ready=0, r_valid=0, r_data=0, r_resp=0, aw_ready=0, w_ready=0, b_valid=0, b_resp=0.
  - Ready signals rise on the first clock edge after deassertion.
  - Reset mid-transaction aborts it: no partial write commits and no response is issued.
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1. The slave never drops a valid before its ready arrives. Valid/ready have no combinational path from ready to valid.
- Read FSM, states RD_IDLE and RD_RESP:
  - RD_IDLE: ar_ready=1. On AR handshake, capture r_data=mem[ar_address] and r_resp=OKAY if ar_address < arr_size; otherwise r_data=0, r_resp=SLVERR. Go to RD_RESP.
  - RD_RESP: ar_ready=0, r_valid=1; r_data and r_resp are held stable. On r_ready, go to RD_IDLE.
  - Latency: r_valid high exactly one cycle after AR handshake. Maximum throughput is one read per 2 cycles.
- Write FSM, states WR_IDLE, WR_COMMIT, WR_RESP:
  - WR_IDLE: aw_ready=!aw_held and w_ready=!w_held. AW and W are accepted independently, in either order or the same cycle, and each is latched into its holding register.
  - When both are held, or a final handshake completes the pair, go to WR_COMMIT next cycle.
  - WR_COMMIT (1 cycle): aw_ready=w_ready=0. If addr < arr_size, write mem[addr]=data and set b_resp=OKAY; otherwise skip the write and set b_resp=SLVERR. Clear both held flags. Go to WR_RESP.
  - WR_RESP: b_valid=1; on b_ready, go to WR_IDLE.
  - A second AW or W is not accepted until the B handshake completes.
- Read/write collision: if an AR handshake coincides with a WR_COMMIT to the same address, the read returns the old (pre-write) value.
- Host write: commits mem[host_addr]=host_wdata on the edge only when the write FSM is not in WR_COMMIT. A host write during WR_COMMIT is dropped (AXI has priority).
- Range: comparison is unsigned. arr_size=0 makes every access SLVERR. The full depth is reachable only by the host port.

Decomposition:
- Shared package sort_pkg:
  - RESP_OKAY/RESP_SLVERR constants.
  - Read and write state encodings.
  - Default width constants, shared with the datapath and controller.
- Sub-module sort_mem_array: the register array with one synchronous write port (mux of AXI commit and host), two combinational read ports, and asynchronous clear.
- Handshake FSMs stay in the top module.

Test Plan:
- Reset then host preload mem[0..3]={7,3,9,1}, arr_size=4; AR addr 2 with r_ready=1 -> r_valid one cycle after AR handshake, r_data=9, r_resp=0.
- W (data 5) presented 3 cycles before AW (addr 1) -> both accepted; write commits; b_valid with b_resp=0; host_rdata at addr 1 = 5.
- AW addr 6, W data 0xDEAD with arr_size=4 -> b_resp=1, mem[6] unchanged (0); AR addr 4 -> r_data=0, r_resp=1.
- r_ready held low 5 cycles -> r_valid/r_data stable throughout; ar_ready=0 until the R handshake completes.
- AR addr 1 in the same cycle as a WR_COMMIT of 8 to addr 1 holding old value 3 -> r_data=3; a following read returns 8.
- rst_n pulsed low during WR_RESP after writing 4 to addr 0 -> b_valid drops immediately; mem[0]=0 after reset; FSMs idle.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared constants and state encodings for the insertion-sort block family.
// Latency: none, declarations only.
// Backpressure: not applicable.
package sort_pkg;

  // Default widths shared by the datapath, controller and array storage
  localparam int DEF_ADDR_WDTH = 4;
  localparam int DEF_DATA_WDTH = 32;
  localparam int DEF_RESP_WDTH = 1;

  // Response codes, widened at the point of use to RESP_WDTH
  localparam int unsigned RESP_OKAY   = 0;
  localparam int unsigned RESP_SLVERR = 1;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_COMMIT = 2'd1,
    WR_RESP   = 2'd2
  } wr_state_t;

endpackage

// File: rtl/sort_array_mem_if.sv
// AR/R/AW/W/B handshake bundle between the sort datapath and its array storage.
// Latency: none, wires only.
// Backpressure: plain valid/ready on every channel; master drives requests, slave drives responses.
interface sort_array_mem_if import sort_pkg::*; #(
  parameter int ADDR_WDTH = DEF_ADDR_WDTH,
  parameter int DATA_WDTH = DEF_DATA_WDTH,
  parameter int RESP_WDTH = DEF_RESP_WDTH
);

  logic                 ar_valid;
  logic                 ar_ready;
  logic [ADDR_WDTH-1:0] ar_address;

  logic                 r_valid;
  logic                 r_ready;
  logic [DATA_WDTH-1:0] r_data;
  logic [RESP_WDTH-1:0] r_resp;

  logic                 aw_valid;
  logic                 aw_ready;
  logic [ADDR_WDTH-1:0] aw_address;

  logic                 w_valid;
  logic                 w_ready;
  logic [DATA_WDTH-1:0] w_data;

  logic                 b_valid;
  logic                 b_ready;
  logic [RESP_WDTH-1:0] b_resp;

  modport master (
    output ar_valid, ar_address, input ar_ready,
    input  r_valid, r_data, r_resp, output r_ready,
    output aw_valid, aw_address, input aw_ready,
    output w_valid, w_data, input w_ready,
    input  b_valid, b_resp, output b_ready
  );

  modport slave (
    input  ar_valid, ar_address, output ar_ready,
    output r_valid, r_data, r_resp, input r_ready,
    input  aw_valid, aw_address, output aw_ready,
    input  w_valid, w_data, output w_ready,
    output b_valid, b_resp, input b_ready
  );

endinterface

// File: rtl/sort_mem_array.sv
// Register array: one synchronous write port, two combinational read ports.
// Latency: write lands on the clock edge; reads are same-cycle combinational.
// Backpressure: none, every write strobe is taken.
module sort_mem_array import sort_pkg::*; #(
  parameter int ADDR_WDTH = DEF_ADDR_WDTH,
  parameter int DATA_WDTH = DEF_DATA_WDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_WDTH-1:0] waddr,
  input  logic [DATA_WDTH-1:0] wdata,
  input  logic [ADDR_WDTH-1:0] ra_addr,
  output logic [DATA_WDTH-1:0] ra_data,
  input  logic [ADDR_WDTH-1:0] rb_addr,
  output logic [DATA_WDTH-1:0] rb_data
);

  localparam int DEPTH = 1 << ADDR_WDTH;

  logic [DATA_WDTH-1:0] mem [DEPTH];

  // Whole array clears on reset; otherwise a single write per edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-edge write is not visible
  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];

endmodule

// File: rtl/sort_array_mem.sv
// Array storage slave for the insertion sort: AR/R reads, AW/W/B writes, host side-port.
// Latency: R valid one cycle after AR handshake; B valid two cycles after the AW/W pair completes.
// Backpressure: each channel holds valid until ready; no new AR/AW/W accepted until R/B handshake.
module sort_array_mem import sort_pkg::*; #(
  parameter int ADDR_WDTH = DEF_ADDR_WDTH,
  parameter int DATA_WDTH = DEF_DATA_WDTH,
  parameter int RESP_WDTH = DEF_RESP_WDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_WDTH-1:0] arr_size,
  sort_array_mem_if.slave      bus,
  input  logic                 host_we,
  input  logic [ADDR_WDTH-1:0] host_addr,
  input  logic [DATA_WDTH-1:0] host_wdata,
  output logic [DATA_WDTH-1:0] host_rdata
);

  localparam logic [RESP_WDTH-1:0] OKAY   = RESP_WDTH'(RESP_OKAY);
  localparam logic [RESP_WDTH-1:0] SLVERR = RESP_WDTH'(RESP_SLVERR);

  rd_state_t            rd_state;
  wr_state_t            wr_state;

  logic                 aw_held;
  logic                 w_held;
  logic [ADDR_WDTH-1:0] aw_addr_q;
  logic [DATA_WDTH-1:0] w_data_q;

  logic                 ar_hs;
  logic                 aw_hs;
  logic                 w_hs;
  logic                 aw_got;
  logic                 w_got;
  logic                 ar_in_range;
  logic                 wr_in_range;

  logic                 mem_we;
  logic [ADDR_WDTH-1:0] mem_waddr;
  logic [DATA_WDTH-1:0] mem_wdata;
  logic [DATA_WDTH-1:0] ar_rdata;

  assign ar_hs  = bus.ar_valid & bus.ar_ready;
  assign aw_hs  = bus.aw_valid & bus.aw_ready;
  assign w_hs   = bus.w_valid & bus.w_ready;
  // Half of the write pair is present if already latched or arriving this edge
  assign aw_got = aw_held | aw_hs;
  assign w_got  = w_held | w_hs;

  // Unsigned compare; arr_size of zero rejects every address
  assign ar_in_range = (bus.ar_address < arr_size);
  assign wr_in_range = (aw_addr_q < arr_size);

  // Single write port: AXI commit owns it in WR_COMMIT, host gets it otherwise
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = host_addr;
    mem_wdata = host_wdata;
    if (wr_state == WR_COMMIT) begin
      if (wr_in_range) begin
        mem_we    = 1'b1;
        mem_waddr = aw_addr_q;
        mem_wdata = w_data_q;
      end
    end else if (host_we) begin
      mem_we = 1'b1;
    end
  end

  sort_mem_array #(
    .ADDR_WDTH (ADDR_WDTH),
    .DATA_WDTH (DATA_WDTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .ra_addr (bus.ar_address),
    .ra_data (ar_rdata),
    .rb_addr (host_addr),
    .rb_data (host_rdata)
  );

  // Read FSM: capture data on AR handshake, hold R until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state     <= RD_IDLE;
      bus.ar_ready <= 1'b0;
      bus.r_valid  <= 1'b0;
      bus.r_data   <= '0;
      bus.r_resp   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            bus.ar_ready <= 1'b0;
            bus.r_valid  <= 1'b1;
            bus.r_data   <= ar_in_range ? ar_rdata : '0;
            bus.r_resp   <= ar_in_range ? OKAY : SLVERR;
            rd_state     <= RD_RESP;
          end else begin
            bus.ar_ready <= 1'b1;
          end
        end
        RD_RESP: begin
          if (bus.r_ready) begin
            bus.r_valid  <= 1'b0;
            bus.ar_ready <= 1'b1;
            rd_state     <= RD_IDLE;
          end
        end
        default: begin
          bus.ar_ready <= 1'b0;
          bus.r_valid  <= 1'b0;
          rd_state     <= RD_IDLE;
        end
      endcase
    end
  end

  // Write FSM: collect AW and W in any order, commit for one cycle, then hold B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state     <= WR_IDLE;
      bus.aw_ready <= 1'b0;
      bus.w_ready  <= 1'b0;
      bus.b_valid  <= 1'b0;
      bus.b_resp   <= '0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= bus.aw_address;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= bus.w_data;
          end
          if (aw_got && w_got) begin
            bus.aw_ready <= 1'b0;
            bus.w_ready  <= 1'b0;
            wr_state     <= WR_COMMIT;
          end else begin
            bus.aw_ready <= !aw_got;
            bus.w_ready  <= !w_got;
          end
        end
        WR_COMMIT: begin
          bus.b_resp  <= wr_in_range ? OKAY : SLVERR;
          bus.b_valid <= 1'b1;
          aw_held     <= 1'b0;
          w_held      <= 1'b0;
          wr_state    <= WR_RESP;
        end
        WR_RESP: begin
          if (bus.b_ready) begin
            bus.b_valid  <= 1'b0;
            bus.aw_ready <= 1'b1;
            bus.w_ready  <= 1'b1;
            wr_state     <= WR_IDLE;
          end
        end
        default: begin
          bus.aw_ready <= 1'b0;
          bus.w_ready  <= 1'b0;
          bus.b_valid  <= 1'b0;
          aw_held      <= 1'b0;
          w_held       <= 1'b0;
          wr_state     <= WR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_array_mem.sv
// Directed bench for sort_array_mem: reads, writes, range errors, stalls, collisions, reset abort.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: r_ready/b_ready steered per step.
module tb_sort_array_mem;
  import sort_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  arr_size;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rd_data;
  logic [0:0]  rd_resp;
  logic [0:0]  wr_resp;
  logic        got;

  sort_array_mem_if #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) bus ();

  sort_array_mem #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arr_size   (arr_size),
    .bus        (bus),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [31:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    @(negedge clk);
    host_we    = 1'b0;
  endtask

  task automatic host_rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    host_addr = a;
    #1;
    chk(tag, host_rdata, exp);
  endtask

  // Read with r_ready high; assumes the read side is idle
  task automatic axi_rd(input string tag, input logic [3:0] a,
                        output logic [31:0] d, output logic [0:0] r);
    logic seen;
    seen           = 1'b0;
    d              = '0;
    r              = '0;
    bus.ar_valid   = 1'b1;
    bus.ar_address = a;
    bus.r_ready    = 1'b1;
    @(negedge clk);
    bus.ar_valid   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.r_valid) begin
        seen = 1'b1;
        d    = bus.r_data;
        r    = bus.r_resp;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_rvalid_seen"}, 32'(seen), 1);
    @(negedge clk);
    bus.r_ready = 1'b0;
  endtask

  // Write with AW and W together and b_ready high; assumes the write side is idle
  task automatic axi_wr(input string tag, input logic [3:0] a, input logic [31:0] d,
                        output logic [0:0] r);
    logic seen;
    seen           = 1'b0;
    r              = '0;
    bus.aw_valid   = 1'b1;
    bus.aw_address = a;
    bus.w_valid    = 1'b1;
    bus.w_data     = d;
    bus.b_ready    = 1'b1;
    @(negedge clk);
    bus.aw_valid   = 1'b0;
    bus.w_valid    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.b_valid) begin
        seen = 1'b1;
        r    = bus.b_resp;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_bvalid_seen"}, 32'(seen), 1);
    @(negedge clk);
    bus.b_ready = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    arr_size       = 4'd0;
    host_we        = 1'b0;
    host_addr      = 4'd0;
    host_wdata     = 32'd0;
    bus.ar_valid   = 1'b0;
    bus.ar_address = 4'd0;
    bus.r_ready    = 1'b0;
    bus.aw_valid   = 1'b0;
    bus.aw_address = 4'd0;
    bus.w_valid    = 1'b0;
    bus.w_data     = 32'd0;
    bus.b_ready    = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ar_ready", 32'(bus.ar_ready), 0);
    chk("rst_r_valid",  32'(bus.r_valid),  0);
    chk("rst_r_data",   bus.r_data,        0);
    chk("rst_r_resp",   32'(bus.r_resp),   0);
    chk("rst_aw_ready", 32'(bus.aw_ready), 0);
    chk("rst_w_ready",  32'(bus.w_ready),  0);
    chk("rst_b_valid",  32'(bus.b_valid),  0);
    chk("rst_b_resp",   32'(bus.b_resp),   0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ar_ready", 32'(bus.ar_ready), 1);
    chk("post_rst_aw_ready", 32'(bus.aw_ready), 1);
    chk("post_rst_w_ready",  32'(bus.w_ready),  1);

    // Host preload {7,3,9,1}
    host_wr(4'd0, 32'd7);
    host_wr(4'd1, 32'd3);
    host_wr(4'd2, 32'd9);
    host_wr(4'd3, 32'd1);
    host_rd_chk("preload_2", 4'd2, 32'd9);
    arr_size = 4'd4;

    // AR addr 2: r_valid one cycle after handshake
    bus.ar_valid   = 1'b1;
    bus.ar_address = 4'd2;
    bus.r_ready    = 1'b1;
    chk("rd2_rvalid_before", 32'(bus.r_valid), 0);
    @(negedge clk);
    bus.ar_valid = 1'b0;
    chk("rd2_rvalid",   32'(bus.r_valid),  1);
    chk("rd2_rdata",    bus.r_data,        9);
    chk("rd2_rresp",    32'(bus.r_resp),   0);
    chk("rd2_ar_ready", 32'(bus.ar_ready), 0);
    @(negedge clk);
    bus.r_ready = 1'b0;
    chk("rd2_rvalid_drop", 32'(bus.r_valid),  0);
    chk("rd2_ar_ready_up", 32'(bus.ar_ready), 1);

    // W leads AW by three cycles
    bus.w_valid = 1'b1;
    bus.w_data  = 32'd5;
    @(negedge clk);
    bus.w_valid = 1'b0;
    chk("wlead_w_ready",  32'(bus.w_ready),  0);
    chk("wlead_aw_ready", 32'(bus.aw_ready), 1);
    @(negedge clk);
    @(negedge clk);
    bus.aw_valid   = 1'b1;
    bus.aw_address = 4'd1;
    @(negedge clk);
    bus.aw_valid = 1'b0;
    chk("wlead_commit_bvalid",  32'(bus.b_valid),  0);
    chk("wlead_commit_awready", 32'(bus.aw_ready), 0);
    @(negedge clk);
    chk("wlead_bvalid", 32'(bus.b_valid), 1);
    chk("wlead_bresp",  32'(bus.b_resp),  0);
    host_rd_chk("wlead_mem1", 4'd1, 32'd5);
    bus.b_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0;
    chk("wlead_bvalid_drop", 32'(bus.b_valid),  0);
    chk("wlead_awready_up",  32'(bus.aw_ready), 1);
    chk("wlead_wready_up",   32'(bus.w_ready),  1);

    // Out-of-range write and read
    axi_wr("oor_wr", 4'd6, 32'hDEAD, wr_resp);
    chk("oor_wr_bresp", 32'(wr_resp), 1);
    host_rd_chk("oor_wr_mem6", 4'd6, 32'd0);
    axi_rd("oor_rd", 4'd4, rd_data, rd_resp);
    chk("oor_rd_data", rd_data, 0);
    chk("oor_rd_resp", 32'(rd_resp), 1);

    // r_ready stalled for 5 cycles
    bus.ar_valid   = 1'b1;
    bus.ar_address = 4'd0;
    bus.r_ready    = 1'b0;
    @(negedge clk);
    bus.ar_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rvalid",   32'(bus.r_valid),  1);
      chk("stall_rdata",    bus.r_data,        7);
      chk("stall_ar_ready", 32'(bus.ar_ready), 0);
      @(negedge clk);
    end
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    chk("stall_rvalid_drop", 32'(bus.r_valid),  0);
    chk("stall_ar_ready_up", 32'(bus.ar_ready), 1);

    // Read/write collision on addr 1 plus a host write dropped during commit
    host_wr(4'd1, 32'd3);
    bus.aw_valid   = 1'b1;
    bus.aw_address = 4'd1;
    bus.w_valid    = 1'b1;
    bus.w_data     = 32'd8;
    bus.b_ready    = 1'b0;
    @(negedge clk);
    bus.aw_valid   = 1'b0;
    bus.w_valid    = 1'b0;
    bus.ar_valid   = 1'b1;
    bus.ar_address = 4'd1;
    bus.r_ready    = 1'b0;
    host_we        = 1'b1;
    host_addr      = 4'd5;
    host_wdata     = 32'h55;
    @(negedge clk);
    bus.ar_valid = 1'b0;
    host_we      = 1'b0;
    chk("coll_rvalid", 32'(bus.r_valid), 1);
    chk("coll_rdata",  bus.r_data,       3);
    chk("coll_bvalid", 32'(bus.b_valid), 1);
    chk("coll_bresp",  32'(bus.b_resp),  0);
    host_rd_chk("coll_mem1", 4'd1, 32'd8);
    host_rd_chk("coll_host_dropped", 4'd5, 32'd0);
    bus.r_ready = 1'b1;
    bus.b_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    bus.b_ready = 1'b0;
    axi_rd("coll_reread", 4'd1, rd_data, rd_resp);
    chk("coll_reread_data", rd_data, 8);
    chk("coll_reread_resp", 32'(rd_resp), 0);

    // arr_size of zero rejects everything, including address 0
    arr_size = 4'd0;
    axi_rd("zero_rd", 4'd0, rd_data, rd_resp);
    chk("zero_rd_data", rd_data, 0);
    chk("zero_rd_resp", 32'(rd_resp), 1);
    axi_wr("zero_wr", 4'd0, 32'h77, wr_resp);
    chk("zero_wr_bresp", 32'(wr_resp), 1);
    host_rd_chk("zero_wr_mem0", 4'd0, 32'd7);
    arr_size = 4'd4;

    // Host reaches beyond arr_size
    host_wr(4'd15, 32'hABCD);
    host_rd_chk("host_top_word", 4'd15, 32'hABCD);

    // Reset pulsed while the write response is pending
    bus.aw_valid   = 1'b1;
    bus.aw_address = 4'd0;
    bus.w_valid    = 1'b1;
    bus.w_data     = 32'd4;
    bus.b_ready    = 1'b0;
    @(negedge clk);
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.b_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rstmid_bvalid_seen", 32'(got), 1);
    host_rd_chk("rstmid_mem0_written", 4'd0, 32'd4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_bvalid_drop", 32'(bus.b_valid),  0);
    chk("rstmid_ar_ready",    32'(bus.ar_ready), 0);
    chk("rstmid_aw_ready",    32'(bus.aw_ready), 0);
    host_rd_chk("rstmid_mem0_clear", 4'd0, 32'd0);
    host_rd_chk("rstmid_mem15_clear", 4'd15, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_idle_ar_ready", 32'(bus.ar_ready), 1);
    chk("rstmid_idle_aw_ready", 32'(bus.aw_ready), 1);
    chk("rstmid_idle_w_ready",  32'(bus.w_ready),  1);
    chk("rstmid_idle_b_valid",  32'(bus.b_valid),  0);
    chk("rstmid_idle_r_valid",  32'(bus.r_valid),  0);
    axi_wr("rstmid_after_wr", 4'd2, 32'h11, wr_resp);
    chk("rstmid_after_bresp", 32'(wr_resp), 0);
    host_rd_chk("rstmid_after_mem2", 4'd2, 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
